temporizador_eventos_jogo: RTL and testbench
============================================

// Module: temporizador_eventos_jogo
// PURPOSE
//  Consumer of the difficulty-interval outputs (tempo_gera_aste, tempo_move_aste,
//  tempo_move_tiro). Turns each interval into a periodic event, three channels
//  (0=gera_aste, 1=move_aste, 2=move_tiro). Each event is held as a pending request
//  until the game FSM acknowledges it. Lost events are counted per channel.
// PARAMETERS
//  W       64  width of the period inputs and the internal counters
//  PERD_W  4   width of each saturating lost-event counter
// PORTS
//  clock           in   1       system clock; all logic on posedge
//  clr_n           in   1       synchronous reset, active low
//  enable          in   1       1 = counters run; 0 = pause (counters hold)
//  sync            in   1       restart all channels (synchronous, 1-cycle pulse)
//  tempo_gera_aste in   W       period, channel 0, in clock cycles
//  tempo_move_aste in   W       period, channel 1, in clock cycles
//  tempo_move_tiro in   W       period, channel 2, in clock cycles
//  ack             in   3       ack[i] consumes pending request i
//  tick            out  3       tick[i] = 1-cycle pulse on each channel-i event
//  req             out  3       req[i] = channel-i event pending
//  perdidos_gera   out  PERD_W  lost events, channel 0 (saturating)
//  perdidos_move   out  PERD_W  lost events, channel 1 (saturating)
//  perdidos_tiro   out  PERD_W  lost events, channel 2 (saturating)
// BEHAVIOUR
//  - Priority per edge: clr_n==0 > sync==1 > normal operation.
//  - Reset (clr_n==0): cnt[i]=0, tick=0, req=0, perdidos_*=0; per_lat[i] <= input.
//  - Effective period: Pe[i] = (per_lat[i]==0) ? 1 : per_lat[i].
//  - Normal, enable==1: if cnt[i]==Pe[i]-1 then cnt[i]<=0, tick[i]<=1,
//    per_lat[i]<=input (reload); else cnt[i]<=cnt[i]+1, tick[i]<=0.
//  - tick is registered. With Pe=P and enable=1 from the first edge after reset,
//    tick is high in cycles P, 2P, 3P... Width is exactly 1 cycle (Pe=1: constant 1).
//  - Period changes mid-interval do not affect the current interval. The new
//    value takes effect from the next reload, sync or reset.
//  - Counters never exceed Pe-1, so there is no wrap-around. W-bit compare only.
//  - enable==0: cnt and per_lat hold, tick<=0. req/ack/perdidos still operate.
//  - sync==1: cnt<=0, tick<=0, req<=0, per_lat<=inputs. perdidos_* unchanged.
//    The next tick is Pe cycles after sync deasserts (with enable=1).
//  - Pending, per channel, evaluated on the same edge that sets tick[i]<=1
//    (call it ev[i]):
//      ev & !req           -> req<=1
//      ev & req & ack      -> req stays 1 (new event replaces consumed one)
//      ev & req & !ack     -> req stays 1; perdidos_i++ (saturates at 2^PERD_W-1)
//      !ev & req & ack     -> req<=0
//      ack & !req          -> ignored
//  - Channels are fully independent. Simultaneous events on several channels
//    are all honoured in the same cycle.
//  - clr_n low mid-interval: everything returns to reset values on that edge.
//    No tick is emitted for the partial interval.
// TESTING
//  1. tempo_move_tiro=4, enable=1 after reset -> tick[2] high cycles 4,8,12 only;
//     req[2] rises cycle 4.
//  2. P=10; change input to 3 at cycle 5 -> tick at 10, then 13, 16.
//  3. P=0 on ch0 -> tick[0] high every enabled cycle; no ack -> perdidos_gera
//     counts to 15 and holds.
//  4. req[1]=1, ack[1] and event on same edge -> req[1] stays 1,
//     perdidos_move unchanged; ack alone next edge -> req[1]=0.
//  5. P=8, enable low cycles 3..6 -> first tick delayed by 4 cycles (cycle 12).
//     sync at cycle 5 of an interval -> cnt=0, req=0, next tick 8 cycles later.
//  6. clr_n low mid-interval with req=3'b111, perdidos=5 -> all outputs 0 next edge.

Source files
------------

// File: rtl/temporizador_eventos_jogo.sv
// -----------------------------------------------------------------------------
// temporizador_eventos_jogo
//
// Turns three difficulty intervals into periodic game events:
//   channel 0 = gera_aste, channel 1 = move_aste, channel 2 = move_tiro.
// Each event raises a one-cycle tick and a pending request that stays up until
// the game FSM acknowledges it. An event that arrives while the previous one
// is still unacknowledged is counted as lost (saturating counter per channel).
//
// Parameters
//   W       width of the period inputs and the interval counters
//   PERD_W  width of each saturating lost-event counter
//
// Ports
//   clock            in   system clock, all logic on posedge
//   clr_n            in   synchronous reset, active low
//   enable           in   1 = counters run, 0 = counters hold
//   sync             in   restart all channels (1-cycle pulse)
//   tempo_gera_aste  in   period of channel 0, in clock cycles
//   tempo_move_aste  in   period of channel 1, in clock cycles
//   tempo_move_tiro  in   period of channel 2, in clock cycles
//   ack              in   ack[i] consumes pending request i
//   tick             out  tick[i] one-cycle pulse per channel-i event
//   req              out  req[i] channel-i event pending
//   perdidos_gera    out  lost events, channel 0
//   perdidos_move    out  lost events, channel 1
//   perdidos_tiro    out  lost events, channel 2
// -----------------------------------------------------------------------------
module temporizador_eventos_jogo #(
    parameter int W      = 64,
    parameter int PERD_W = 4
) (
    input  logic              clock,
    input  logic              clr_n,
    input  logic              enable,
    input  logic              sync,
    input  logic [W-1:0]      tempo_gera_aste,
    input  logic [W-1:0]      tempo_move_aste,
    input  logic [W-1:0]      tempo_move_tiro,
    input  logic [2:0]        ack,
    output logic [2:0]        tick,
    output logic [2:0]        req,
    output logic [PERD_W-1:0] perdidos_gera,
    output logic [PERD_W-1:0] perdidos_move,
    output logic [PERD_W-1:0] perdidos_tiro
);

    logic [W-1:0]      per_in    [3];
    logic [W-1:0]      last_cnt  [3];
    logic [W-1:0]      cnt_q     [3];
    logic [W-1:0]      cnt_d     [3];
    logic [W-1:0]      per_lat_q [3];
    logic [W-1:0]      per_lat_d [3];
    logic [PERD_W-1:0] perd_q    [3];
    logic [PERD_W-1:0] perd_d    [3];
    logic [2:0]        tick_q, tick_d;
    logic [2:0]        req_q, req_d;
    logic [2:0]        ev;

    function automatic logic [PERD_W-1:0] sat_inc(input logic [PERD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        per_in[0] = tempo_gera_aste;
        per_in[1] = tempo_move_aste;
        per_in[2] = tempo_move_tiro;
        ev        = '0;
        tick_d    = '0;
        req_d     = req_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]     = cnt_q[i];
            per_lat_d[i] = per_lat_q[i];
            perd_d[i]    = perd_q[i];
            // A latched period of 0 behaves as 1, so the terminal count is 0.
            last_cnt[i]  = (per_lat_q[i] == '0) ? '0 : per_lat_q[i] - 1'b1;

            if (enable) begin
                if (cnt_q[i] == last_cnt[i]) begin
                    ev[i]        = 1'b1;
                    cnt_d[i]     = '0;
                    tick_d[i]    = 1'b1;
                    // New period only takes effect at an interval boundary.
                    per_lat_d[i] = per_in[i];
                end else begin
                    cnt_d[i]     = cnt_q[i] + 1'b1;
                end
            end

            if (ev[i]) begin
                // A fresh event always leaves a request pending; it is lost
                // only if the previous one was not consumed on this edge.
                req_d[i] = 1'b1;
                if (req_q[i] && !ack[i]) begin
                    perd_d[i] = sat_inc(perd_q[i]);
                end
            end else if (req_q[i] && ack[i]) begin
                req_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]     <= '0;
                per_lat_q[i] <= per_in[i];
                perd_q[i]    <= '0;
            end
            tick_q <= '0;
            req_q  <= '0;
        end else if (sync) begin
            // Restart intervals but keep the lost-event history.
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]     <= '0;
                per_lat_q[i] <= per_in[i];
                perd_q[i]    <= perd_q[i];
            end
            tick_q <= '0;
            req_q  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]     <= cnt_d[i];
                per_lat_q[i] <= per_lat_d[i];
                perd_q[i]    <= perd_d[i];
            end
            tick_q <= tick_d;
            req_q  <= req_d;
        end
    end

    assign tick          = tick_q;
    assign req           = req_q;
    assign perdidos_gera = perd_q[0];
    assign perdidos_move = perd_q[1];
    assign perdidos_tiro = perd_q[2];

endmodule

// File: tb/tb_temporizador_eventos_jogo.sv
// -----------------------------------------------------------------------------
// Directed bench for temporizador_eventos_jogo. Cycle n is the state seen just
// after the n-th rising edge following reset release.
// -----------------------------------------------------------------------------
module tb_temporizador_eventos_jogo;

    localparam int W      = 64;
    localparam int PERD_W = 4;

    logic              clock = 1'b0;
    logic              clr_n;
    logic              enable;
    logic              sync;
    logic [W-1:0]      tempo_gera_aste;
    logic [W-1:0]      tempo_move_aste;
    logic [W-1:0]      tempo_move_tiro;
    logic [2:0]        ack;
    logic [2:0]        tick;
    logic [2:0]        req;
    logic [PERD_W-1:0] perdidos_gera;
    logic [PERD_W-1:0] perdidos_move;
    logic [PERD_W-1:0] perdidos_tiro;

    int errors = 0;
    int checks = 0;

    temporizador_eventos_jogo #(.W(W), .PERD_W(PERD_W)) dut (
        .clock           (clock),
        .clr_n           (clr_n),
        .enable          (enable),
        .sync            (sync),
        .tempo_gera_aste (tempo_gera_aste),
        .tempo_move_aste (tempo_move_aste),
        .tempo_move_tiro (tempo_move_tiro),
        .ack             (ack),
        .tick            (tick),
        .req             (req),
        .perdidos_gera   (perdidos_gera),
        .perdidos_move   (perdidos_move),
        .perdidos_tiro   (perdidos_tiro)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] g, input logic [W-1:0] m, input logic [W-1:0] t);
        tempo_gera_aste = g;
        tempo_move_aste = m;
        tempo_move_tiro = t;
        ack    = 3'b000;
        sync   = 1'b0;
        enable = 1'b1;
        clr_n  = 1'b0;
        step();
        step();
        clr_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(64'd5, 64'd5, 64'd5);
        checks++;
        if (tick !== 3'b000) begin
            errors++; $display("FAIL reset_tick: got %b expected %b", tick, 3'b000);
        end
        checks++;
        if (req !== 3'b000) begin
            errors++; $display("FAIL reset_req: got %b expected %b", req, 3'b000);
        end
        checks++;
        if ({perdidos_gera, perdidos_move, perdidos_tiro} !== 12'h000) begin
            errors++; $display("FAIL reset_perd: got %h expected 000",
                               {perdidos_gera, perdidos_move, perdidos_tiro});
        end
    endtask

    task automatic test_period4();
        logic exp_t, exp_r;
        do_reset(64'd1000, 64'd1000, 64'd4);
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_t = (c % 4 == 0);
            exp_r = (c >= 4);
            checks++;
            if (tick !== {exp_t, 2'b00}) begin
                errors++; $display("FAIL period4_tick c=%0d: got %b expected %b", c, tick, {exp_t, 2'b00});
            end
            checks++;
            if (req[2] !== exp_r) begin
                errors++; $display("FAIL period4_req c=%0d: got %b expected %b", c, req[2], exp_r);
            end
        end
    endtask

    task automatic test_period_change();
        logic exp_t;
        do_reset(64'd1000, 64'd10, 64'd1000);
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 5) tempo_move_aste = 64'd3;
            exp_t = (c == 10) || (c == 13) || (c == 16);
            checks++;
            if (tick[1] !== exp_t) begin
                errors++; $display("FAIL period_change_tick c=%0d: got %b expected %b", c, tick[1], exp_t);
            end
        end
    endtask

    task automatic test_zero_period_saturation();
        logic [PERD_W-1:0] exp_p;
        do_reset(64'd0, 64'd1000, 64'd1000);
        for (int c = 1; c <= 20; c++) begin
            step();
            exp_p = (c - 1 > 15) ? 4'd15 : 4'(c - 1);
            checks++;
            if (tick[0] !== 1'b1 || req[0] !== 1'b1) begin
                errors++; $display("FAIL zero_period_tick_req c=%0d: got tick=%b req=%b expected 1 1",
                                   c, tick[0], req[0]);
            end
            checks++;
            if (perdidos_gera !== exp_p) begin
                errors++; $display("FAIL zero_period_perd c=%0d: got %0d expected %0d", c, perdidos_gera, exp_p);
            end
        end
    endtask

    task automatic test_ack();
        do_reset(64'd1000, 64'd3, 64'd1000);
        step(); step(); step();
        checks++;
        if (tick[1] !== 1'b1 || req[1] !== 1'b1) begin
            errors++; $display("FAIL ack_first_event: got tick=%b req=%b expected 1 1", tick[1], req[1]);
        end
        step(); step();
        ack = 3'b010;
        step(); // cycle 6: event and ack together
        checks++;
        if (tick[1] !== 1'b1 || req[1] !== 1'b1 || perdidos_move !== 4'd0) begin
            errors++; $display("FAIL ack_with_event: got tick=%b req=%b perd=%0d expected 1 1 0",
                               tick[1], req[1], perdidos_move);
        end
        step(); // cycle 7: ack alone clears
        checks++;
        if (req[1] !== 1'b0 || tick[1] !== 1'b0) begin
            errors++; $display("FAIL ack_alone: got req=%b tick=%b expected 0 0", req[1], tick[1]);
        end
        step(); // cycle 8: ack with nothing pending
        checks++;
        if (req[1] !== 1'b0) begin
            errors++; $display("FAIL ack_idle: got req=%b expected 0", req[1]);
        end
        ack = 3'b000;
        step(); // cycle 9: event into empty slot
        checks++;
        if (tick[1] !== 1'b1 || req[1] !== 1'b1 || perdidos_move !== 4'd0) begin
            errors++; $display("FAIL ack_refill: got tick=%b req=%b perd=%0d expected 1 1 0",
                               tick[1], req[1], perdidos_move);
        end
        step(); step(); step(); // cycle 12: event while pending, no ack
        checks++;
        if (req[1] !== 1'b1 || perdidos_move !== 4'd1) begin
            errors++; $display("FAIL ack_lost: got req=%b perd=%0d expected 1 1", req[1], perdidos_move);
        end
    endtask

    task automatic test_enable();
        logic exp_t;
        do_reset(64'd8, 64'd1000, 64'd1000);
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_t = (c == 12);
            checks++;
            if (tick[0] !== exp_t) begin
                errors++; $display("FAIL enable_tick c=%0d: got %b expected %b", c, tick[0], exp_t);
            end
            enable = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
        end
        enable = 1'b1;
    endtask

    task automatic test_sync();
        logic exp_t;
        do_reset(64'd8, 64'd1000, 64'd1000);
        for (int c = 1; c <= 13; c++) step();
        checks++;
        if (req[0] !== 1'b1) begin
            errors++; $display("FAIL sync_pre_req: got %b expected 1", req[0]);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (req[0] !== 1'b0 || tick[0] !== 1'b0) begin
            errors++; $display("FAIL sync_clear: got req=%b tick=%b expected 0 0", req[0], tick[0]);
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_t = (k == 8);
            checks++;
            if (tick[0] !== exp_t) begin
                errors++; $display("FAIL sync_tick k=%0d: got %b expected %b", k, tick[0], exp_t);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(64'd2, 64'd2, 64'd2);
        step();
        checks++;
        if (tick !== 3'b000) begin
            errors++; $display("FAIL simult_c1: got %b expected 000", tick);
        end
        step();
        checks++;
        if (tick !== 3'b111 || req !== 3'b111) begin
            errors++; $display("FAIL simult_c2: got tick=%b req=%b expected 111 111", tick, req);
        end
    endtask

    task automatic test_clear_mid_interval();
        do_reset(64'd1, 64'd1, 64'd1);
        for (int c = 1; c <= 5; c++) step();
        tempo_gera_aste = 64'd100;
        tempo_move_aste = 64'd100;
        tempo_move_tiro = 64'd100;
        step(); step(); step();
        checks++;
        if (req !== 3'b111 || tick !== 3'b000 ||
            {perdidos_gera, perdidos_move, perdidos_tiro} !== 12'h555) begin
            errors++; $display("FAIL clr_setup: got req=%b tick=%b perd=%h expected 111 000 555",
                               req, tick, {perdidos_gera, perdidos_move, perdidos_tiro});
        end
        clr_n = 1'b0;
        step();
        checks++;
        if (req !== 3'b000 || tick !== 3'b000 ||
            {perdidos_gera, perdidos_move, perdidos_tiro} !== 12'h000) begin
            errors++; $display("FAIL clr_mid: got req=%b tick=%b perd=%h expected 000 000 000",
                               req, tick, {perdidos_gera, perdidos_move, perdidos_tiro});
        end
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n = 1'b0;
        enable = 1'b0;
        sync = 1'b0;
        ack = 3'b000;
        tempo_gera_aste = '0;
        tempo_move_aste = '0;
        tempo_move_tiro = '0;
        test_reset();
        test_period4();
        test_period_change();
        test_zero_period_saturation();
        test_ack();
        test_enable();
        test_sync();
        test_back_to_back();
        test_clear_mid_interval();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
